instruction_sequencer: RTL and testbench
========================================

Name: instruction_sequencer

Overview:
- Fetches controller instructions from a synchronous instruction memory and issues them one at a time on the master controller's instruction port.
- Executes three meta-instructions locally: LOOP_START, LOOP_END and HALT. It supports up to 2 nested hardware loops.
- Sits between the host/boot logic (start/done) and the master controller. It replaces host-driven instruction streaming for a convolution layer.

Parameters:
- insWidth, 26, instruction word width: 4 opcode + 2 ins1 + 2*insW + insD, with the depth=2 defaults.
- insD, 16, width of the insLast field (low bits of the word).
- PcW, 8, instruction memory address width.
- CntW, 12, loop count width, taken from insLast[CntW-1:0].
- LoopLevels, 2, loop stack depth.

Ports:
- CLK  in  1  clock; all logic is on its rising edge.
- RSTn  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse. Begins execution at startPc; ignored unless the state is IDLE.
- startPc  in  PcW  first instruction address, sampled when start is accepted.
- stall  in  1  holds the currently issued instruction (downstream busy).
- imemAddr  out  PcW  instruction memory read address.
- imemData  in  insWidth  read data, valid 1 cycle after imemAddr.
- instruction  out  insWidth  to the master controller; holds NOP when nothing is issued.
- insValid  out  1  high for exactly one cycle per non-meta instruction accepted downstream.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on termination.
- error  out  1  sticky fault flag; cleared by reset or by the next accepted start.
- pc  out  PcW  current program counter, for debug.

Behaviour:
- Opcode field is instruction[insWidth-1 -: 4].
- Meta opcodes:
  - 4'b0101 LOOP_START
  - 4'b0110 LOOP_END
  - 4'b0111 HALT
- NOP is {4'b1111, zeros}. The master controller treats it as its default, side-effect-free case. All other opcodes pass through unmodified.
- Reset values: instruction=NOP, insValid=0, busy=0, done=0, error=0, imemAddr=0, pc=0, loop stack empty, state=IDLE.
- State machine (IDLE, FETCH, ISSUE, DONE):
  - IDLE: on start, pc<=startPc, clear error, go to FETCH.
  - FETCH: imemAddr=pc; go to ISSUE next cycle, when imemData is valid.
  - ISSUE, non-meta instruction:
    - Drive instruction=imemData.
    - If stall=0: insValid=1, pc<=pc+1, go to FETCH.
    - If stall=1: hold the same word with insValid=0 and stay in ISSUE; imemAddr is held so the data remains valid.
  - ISSUE, LOOP_START: push {pc+1, N}, where N=insLast[CntW-1:0] and N=0 is treated as 1. Then pc<=pc+1, go to FETCH. instruction=NOP; stall is ignored.
  - ISSUE, LOOP_END:
    - If the top count >1: decrement it, pc<=top start address.
    - Else: pop, pc<=pc+1.
    - Go to FETCH; instruction=NOP.
  - ISSUE, HALT: go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Throughput is 1 instruction per 2 cycles without stall. Latency from start to the first insValid is 3 cycles.
- The loop body executes exactly N times. The LOOP_START and LOOP_END words themselves consume FETCH/ISSUE slots but are never issued.
- Error conditions (each sets error=1, emits no insValid, and goes to DONE):
  - LOOP_START with the stack full (LoopLevels entries).
  - LOOP_END with the stack empty.
  - Incrementing pc past 2^PcW-1.
- start while busy is ignored. A stall arriving during meta-instruction or FETCH cycles has no effect.
- Reset asserted mid-run: on the next edge, all state returns to reset values and any in-flight instruction is dropped (insValid=0).
- The loop count register is CntW bits, with decrement only when >1, so it never underflows.

Test Plan:
- Program {LOAD_CONSTANTS, CONVOLVE, HALT} at 0, start with startPc=0 -> insValid at cycles 3 and 5 with the exact words; done pulses at cycle 7; error=0; instruction=NOP in between.
- LOOP_START N=3, CONVOLVE, LOOP_END, HALT -> CONVOLVE issued exactly 3 times; pc sequence 0,1,2,1,2,1,2,3; stack empty at done.
- Nested loops: outer N=2, inner N=3, inner body 1 word -> 6 issues; LOOP_START N=0 -> body issued once.
- stall high 4 cycles during ISSUE of CONVOLVE -> instruction held constant, insValid=0 during stall, then one insValid pulse, no duplicate issue.
- Errors:
  - 3 nested LOOP_STARTs with LoopLevels=2 -> error=1, done pulse, no further issue.
  - Lone LOOP_END -> error=1.
  - Next start -> error cleared.
- Reset pulled low mid-loop with stall high -> next cycle busy=0, insValid=0, instruction=NOP; a new start runs from startPc with an empty stack.

Source files
------------

// File: rtl/instruction_sequencer.sv
// Fetches words from a synchronous instruction memory, executes LOOP_START /
// LOOP_END / HALT locally and issues every other word to the master controller.
module instruction_sequencer #(
   parameter int unsigned insWidth   = 26,
   parameter int unsigned insD       = 16,
   parameter int unsigned PcW        = 8,
   parameter int unsigned CntW       = 12,
   parameter int unsigned LoopLevels = 2
) (
   input  logic                CLK,
   input  logic                RSTn,
   input  logic                start,
   input  logic [PcW-1:0]      startPc,
   input  logic                stall,
   output logic [PcW-1:0]      imemAddr,
   input  logic [insWidth-1:0] imemData,
   output logic [insWidth-1:0] instruction,
   output logic                insValid,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [PcW-1:0]      pc
);
   localparam int unsigned OpW  = 4;
   localparam int unsigned SpW  = $clog2(LoopLevels + 1);
   localparam int unsigned IdxW = (LoopLevels > 1) ? $clog2(LoopLevels) : 1;

   localparam logic [OpW-1:0] OP_LOOP_START = 4'b0101;
   localparam logic [OpW-1:0] OP_LOOP_END   = 4'b0110;
   localparam logic [OpW-1:0] OP_HALT       = 4'b0111;
   localparam logic [insWidth-1:0] NOP = {4'b1111, {(insWidth - OpW){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;

   state_t state, next_state;

   logic [PcW-1:0]      loop_pc  [LoopLevels];
   logic [CntW-1:0]     loop_cnt [LoopLevels];
   logic [SpW-1:0]      sp, sp_n;
   logic [IdxW-1:0]     top, push_idx;
   logic [OpW-1:0]      opcode;
   logic [insD-1:0]     ins_last;
   logic [CntW-1:0]     loop_n, loop_n_eff;
   logic [PcW-1:0]      pc_n, pc_inc;
   logic [insWidth-1:0] instr_n;
   logic                valid_n, done_n, error_n;
   logic                push, dec, fault;
   logic                stack_full, stack_empty, pc_last;

   assign imemAddr    = pc;
   assign opcode      = imemData[insWidth-1 -: OpW];
   assign ins_last    = imemData[insD-1:0];
   assign loop_n      = CntW'(ins_last);
   assign loop_n_eff  = (loop_n == '0) ? CntW'(1) : loop_n;
   assign pc_inc      = pc + PcW'(1);
   assign pc_last     = &pc;
   assign stack_full  = (sp == SpW'(LoopLevels));
   assign stack_empty = (sp == '0);
   assign top         = IdxW'(sp - SpW'(1));
   assign push_idx    = IdxW'(sp);

   // State register
   always_ff @(posedge CLK) begin
      if (!RSTn) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next state, next pc/stack pointer and next output values
   always_comb begin
      next_state = state;
      pc_n       = pc;
      sp_n       = sp;
      push       = 1'b0;
      dec        = 1'b0;
      fault      = 1'b0;
      instr_n    = NOP;
      valid_n    = 1'b0;
      done_n     = 1'b0;
      error_n    = error;
      case (state)
         S_IDLE: begin
            if (start) begin
               next_state = S_FETCH;
               pc_n       = startPc;
               sp_n       = '0;
               error_n    = 1'b0;
            end
         end
         S_FETCH: next_state = S_ISSUE;
         S_ISSUE: begin
            next_state = S_FETCH;
            case (opcode)
               OP_LOOP_START: begin
                  if (stack_full || pc_last) fault = 1'b1;
                  else begin
                     push = 1'b1;
                     sp_n = sp + SpW'(1);
                     pc_n = pc_inc;
                  end
               end
               OP_LOOP_END: begin
                  if (stack_empty) fault = 1'b1;
                  else if (loop_cnt[top] > CntW'(1)) begin
                     dec  = 1'b1;
                     pc_n = loop_pc[top];
                  end else if (pc_last) fault = 1'b1;
                  else begin
                     sp_n = sp - SpW'(1);
                     pc_n = pc_inc;
                  end
               end
               OP_HALT: begin
                  next_state = S_DONE;
                  done_n     = 1'b1;
               end
               default: begin
                  // Stalled words stay on the bus; imemAddr is held so imemData stays valid
                  if (stall) begin
                     next_state = S_ISSUE;
                     instr_n    = imemData;
                  end else if (pc_last) fault = 1'b1;
                  else begin
                     instr_n = imemData;
                     valid_n = 1'b1;
                     pc_n    = pc_inc;
                  end
               end
            endcase
            if (fault) begin
               next_state = S_DONE;
               done_n     = 1'b1;
               error_n    = 1'b1;
            end
         end
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Registered outputs and program counter
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         pc          <= '0;
         sp          <= '0;
         instruction <= NOP;
         insValid    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         pc          <= pc_n;
         sp          <= sp_n;
         instruction <= instr_n;
         insValid    <= valid_n;
         busy        <= (next_state != S_IDLE);
         done        <= done_n;
         error       <= error_n;
      end
   end

   // Loop stack storage; occupancy is tracked by sp
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         for (int i = 0; i < int'(LoopLevels); i++) begin
            loop_pc[i]  <= '0;
            loop_cnt[i] <= '0;
         end
      end else if (push) begin
         loop_pc[push_idx]  <= pc_inc;
         loop_cnt[push_idx] <= loop_n_eff;
      end else if (dec) begin
         loop_cnt[top] <= loop_cnt[top] - CntW'(1);
      end
   end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: program-level interpreter model plus a
// per-cycle scoreboard, with directed programs and literal timing pins.
module tb_instruction_sequencer;
   localparam int unsigned InsW = 26;
   localparam int unsigned PcW  = 8;

   localparam logic [InsW-1:0] NOP    = {4'hF, 22'h0};
   localparam logic [InsW-1:0] W_LOAD = {4'h1, 22'h012345};
   localparam logic [InsW-1:0] W_CONV = {4'h2, 22'h0ABCDE};
   localparam logic [InsW-1:0] W_HALT = {4'h7, 22'h0};
   localparam logic [InsW-1:0] W_LE   = {4'h6, 22'h0};

   logic            clk = 1'b0;
   logic            rst_n, start, stall;
   logic [PcW-1:0]  start_pc, imem_addr, pc;
   logic [InsW-1:0] imem_data, instruction;
   logic            ins_valid, busy, done, error;

   instruction_sequencer dut (
      .CLK(clk), .RSTn(rst_n), .start(start), .startPc(start_pc), .stall(stall),
      .imemAddr(imem_addr), .imemData(imem_data), .instruction(instruction),
      .insValid(ins_valid), .busy(busy), .done(done), .error(error), .pc(pc)
   );

   always #5 clk = ~clk;

   logic [InsW-1:0] mem [256];
   always @(posedge clk) imem_data <= mem[imem_addr];

   int              n_chk = 0;
   int              n_fail = 0;
   logic [InsW-1:0] exp_q[$];
   int              exp_pc_q[$];
   int              dut_pc_q[$];
   logic            exp_err;
   logic            prev_busy = 1'b0;
   logic [InsW-1:0] cmp_w;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_mem();
      for (int i = 0; i < 256; i++) mem[i] = W_HALT;
   endtask

   // Program-level interpreter: issued words, pc trace and error outcome
   task automatic model_run(input int spc);
      int p, depth, n;
      int ls_pc[2];
      int ls_cnt[2];
      logic [InsW-1:0] w;
      p = spc; depth = 0; exp_err = 1'b0;
      exp_q.delete(); exp_pc_q.delete();
      for (int step = 0; step < 2000; step++) begin
         if (exp_pc_q.size() == 0 || exp_pc_q[$] != p) exp_pc_q.push_back(p);
         w = mem[p];
         if (w[25:22] == 4'h7) break;
         else if (w[25:22] == 4'h5) begin
            if (depth == 2 || p == 255) begin exp_err = 1'b1; break; end
            n = int'(w[11:0]);
            if (n == 0) n = 1;
            ls_pc[depth] = p + 1; ls_cnt[depth] = n; depth++; p++;
         end else if (w[25:22] == 4'h6) begin
            if (depth == 0) begin exp_err = 1'b1; break; end
            if (ls_cnt[depth-1] > 1) begin
               ls_cnt[depth-1]--; p = ls_pc[depth-1];
            end else begin
               if (p == 255) begin exp_err = 1'b1; break; end
               depth--; p++;
            end
         end else begin
            if (p == 255) begin exp_err = 1'b1; break; end
            exp_q.push_back(w); p++;
         end
      end
   endtask

   function automatic logic trace_ok();
      if (dut_pc_q.size() != exp_pc_q.size()) return 1'b0;
      foreach (dut_pc_q[i]) if (dut_pc_q[i] != exp_pc_q[i]) return 1'b0;
      return 1'b1;
   endfunction

   // Scoreboard: every issued word must be the next word the model expects
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         prev_busy = 1'b0;
      end else begin
         if (busy && !prev_busy) begin
            dut_pc_q.delete();
            dut_pc_q.push_back(int'(pc));
         end else if (busy && int'(pc) != dut_pc_q[$]) dut_pc_q.push_back(int'(pc));
         prev_busy = busy;
         if (ins_valid) begin
            if (exp_q.size() == 0) chk("unexpected_issue", instruction, NOP);
            else begin
               cmp_w = exp_q.pop_front();
               chk("issued_word", instruction, cmp_w);
            end
         end else if (instruction !== NOP) begin
            chk("held_word_is_pending", (exp_q.size() != 0) && (instruction === exp_q[0]), 1'b1);
         end else begin
            chk("idle_nop", instruction, NOP);
         end
         if (done) begin
            chk("done_error", error, exp_err);
            chk("done_leftover", exp_q.size(), 0);
            chk("done_pc_trace", trace_ok(), 1'b1);
         end
      end
   end

   task automatic run_prog(input logic [7:0] spc, input logic [63:0] smask,
                           output int nv, output int dc, output logic [63:0] vm,
                           output logic [63:0] wm, output logic err1);
      model_run(int'(spc));
      start_pc = spc; start = 1'b1;
      nv = 0; dc = -1; vm = '0; wm = '0; err1 = 1'b1;
      for (int c = 0; c < 400; c++) begin
         stall = (c < 64) ? smask[c] : 1'b0;
         tick();
         start = 1'b0;
         if (c == 0) err1 = error;
         if (ins_valid) nv++;
         if (c + 1 < 64) begin
            vm[c+1] = ins_valid;
            wm[c+1] = (instruction !== NOP);
         end
         if (done) begin dc = c + 1; break; end
      end
      stall = 1'b0;
      if (dc < 0) chk("done_within_budget", done, 1'b1);
      tick(); tick();
   endtask

   int nv, dc, lit_ok;
   logic [63:0] vm, wm;
   logic err1;
   int lit_trace[8] = '{0, 1, 2, 1, 2, 1, 2, 3};

   initial begin
      rst_n = 1'b0; start = 1'b0; stall = 1'b0; start_pc = '0;
      fill_mem();
      repeat (2) tick();
      chk("rst_instruction", instruction, NOP);
      chk("rst_ins_valid", ins_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_error", error, 1'b0);
      chk("rst_imem_addr", imem_addr, 8'h00);
      chk("rst_pc", pc, 8'h00);
      rst_n = 1'b1;
      tick();

      // Straight-line program
      fill_mem(); mem[0] = W_LOAD; mem[1] = W_CONV; mem[2] = W_HALT;
      model_run(0);
      chk("model_basic_count", exp_q.size(), 2);
      chk("model_basic_word1", exp_q[1], W_CONV);
      run_prog(8'd0, 64'h0, nv, dc, vm, wm, err1);
      chk("basic_valid_cycles", vm, 64'h28);
      chk("basic_word_cycles", wm, 64'h28);
      chk("basic_done_cycle", dc, 7);
      chk("basic_error", error, 1'b0);

      // Single loop, N=3
      fill_mem(); mem[0] = {4'h5, 22'd3}; mem[1] = W_CONV; mem[2] = W_LE; mem[3] = W_HALT;
      model_run(0);
      lit_ok = (exp_pc_q.size() == 8) ? 1 : 0;
      for (int i = 0; i < 8 && lit_ok == 1; i++) if (exp_pc_q[i] != lit_trace[i]) lit_ok = 0;
      chk("model_loop_trace", lit_ok, 1);
      run_prog(8'd0, 64'h0, nv, dc, vm, wm, err1);
      chk("loop_issue_count", nv, 3);
      chk("loop_done_cycle", dc, 17);

      // Nested loops: outer N=2 (upper insLast bits ignored), inner N=3
      fill_mem(); mem[0] = {4'h5, 22'h3F002}; mem[1] = {4'h5, 22'd3}; mem[2] = W_CONV;
      mem[3] = W_LE; mem[4] = W_LE; mem[5] = W_HALT;
      model_run(0);
      chk("model_nested_count", exp_q.size(), 6);
      run_prog(8'd0, 64'h0, nv, dc, vm, wm, err1);
      chk("nested_issue_count", nv, 6);
      chk("nested_done_cycle", dc, 37);

      // LOOP_START with count field zero runs the body once
      fill_mem(); mem[0] = {4'h5, 22'h01000}; mem[1] = W_LOAD; mem[2] = W_LE; mem[3] = W_HALT;
      run_prog(8'd0, 64'h0, nv, dc, vm, wm, err1);
      chk("n0_issue_count", nv, 1);
      chk("n0_done_cycle", dc, 9);

      // Four stall cycles during ISSUE of CONVOLVE
      fill_mem(); mem[0] = W_LOAD; mem[1] = W_CONV; mem[2] = W_HALT;
      run_prog(8'd0, 64'hF0, nv, dc, vm, wm, err1);
      chk("stall_valid_cycles", vm, 64'h208);
      chk("stall_word_cycles", wm, 64'h3E8);
      chk("stall_done_cycle", dc, 11);

      // Stack overflow: three nested LOOP_STARTs
      fill_mem(); mem[0] = {4'h5, 22'd2}; mem[1] = {4'h5, 22'd2}; mem[2] = {4'h5, 22'd2};
      mem[3] = W_CONV; mem[4] = W_LE; mem[5] = W_LE; mem[6] = W_LE;
      model_run(0);
      chk("model_overflow_err", exp_err, 1'b1);
      run_prog(8'd0, 64'h0, nv, dc, vm, wm, err1);
      chk("overflow_issues", nv, 0);
      chk("overflow_done_cycle", dc, 7);
      repeat (4) tick();
      chk("error_sticky", error, 1'b1);

      // Lone LOOP_END at a nonzero start address
      fill_mem(); mem[10] = W_LE;
      run_prog(8'd10, 64'h0, nv, dc, vm, wm, err1);
      chk("lone_le_error", error, 1'b1);
      chk("lone_le_done_cycle", dc, 3);

      // Program counter would run past the top of memory
      fill_mem(); mem[255] = W_CONV;
      run_prog(8'd255, 64'h0, nv, dc, vm, wm, err1);
      chk("pc_wrap_error", error, 1'b1);
      chk("pc_wrap_issues", nv, 0);

      // Next start clears the error
      fill_mem(); mem[0] = W_LOAD; mem[1] = W_CONV; mem[2] = W_HALT;
      run_prog(8'd0, 64'h0, nv, dc, vm, wm, err1);
      chk("error_cleared_on_start", err1, 1'b0);
      chk("clean_run_error", error, 1'b0);

      // Reset mid-loop while stalled
      fill_mem(); mem[0] = {4'h5, 22'd3}; mem[1] = W_CONV; mem[2] = W_LE; mem[3] = W_HALT;
      model_run(0);
      start_pc = 8'd0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      stall = 1'b1;
      repeat (3) tick();
      chk("pre_reset_held_word", instruction, W_CONV);
      rst_n = 1'b0;
      tick();
      chk("mid_reset_busy", busy, 1'b0);
      chk("mid_reset_ins_valid", ins_valid, 1'b0);
      chk("mid_reset_instruction", instruction, NOP);
      chk("mid_reset_pc", pc, 8'h00);
      rst_n = 1'b1; stall = 1'b0;
      tick();

      // After reset the two-level nest must fit, so the stack restarted empty
      fill_mem(); mem[0] = {4'h5, 22'd2}; mem[1] = {4'h5, 22'd3}; mem[2] = W_CONV;
      mem[3] = W_LE; mem[4] = W_LE; mem[5] = W_HALT;
      run_prog(8'd0, 64'h0, nv, dc, vm, wm, err1);
      chk("post_reset_issues", nv, 6);
      chk("post_reset_error", error, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
